// File: rtl/ntt_ctrl_pkg.sv
// Shared defaults, FSM state encoding and write-back latency helper for the NTT sequencer.
package ntt_ctrl_pkg;
    localparam int LOG_N_DEF       = 8;
    localparam int MEM_LATENCY_DEF = 1;
    localparam int BF_LATENCY_DEF  = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Cycles from a read strobe to the matching write-back strobe.
    function automatic int wb_lat(input int mem_latency, input int bf_latency);
        return mem_latency + bf_latency;
    endfunction

    function automatic int xform_size(input int log_n);
        return 1 << log_n;
    endfunction
endpackage

// File: rtl/ntt_ctrl_if.sv
// Control bus between the NTT sequencer (master) and the RAM/ROM/butterfly datapath (slave).
interface ntt_ctrl_if
    import ntt_ctrl_pkg::*;
#(
    parameter int LOG_N = LOG_N_DEF
);
    logic             start;
    logic             mode;
    logic             busy;
    logic             done;
    logic             select;
    logic [LOG_N-1:0] stage;
    logic             rd_en;
    logic [LOG_N-1:0] rd_addr_1;
    logic [LOG_N-1:0] rd_addr_2;
    logic [LOG_N-1:0] tw_addr;
    logic             wr_en;
    logic [LOG_N-1:0] wr_addr_1;
    logic [LOG_N-1:0] wr_addr_2;

    modport master (
        input  start, mode,
        output busy, done, select, stage,
        output rd_en, rd_addr_1, rd_addr_2, tw_addr,
        output wr_en, wr_addr_1, wr_addr_2
    );

    modport slave (
        output start, mode,
        input  busy, done, select, stage,
        input  rd_en, rd_addr_1, rd_addr_2, tw_addr,
        input  wr_en, wr_addr_1, wr_addr_2
    );
endinterface

// File: rtl/ntt_ctrl_wr_delay.sv
// LAT-deep shift register turning {rd_en, rd_addr_1, rd_addr_2} into write-back strobes/addresses.
// Latency LAT cycles, no backpressure; reset flushes every pending write.
module ntt_ctrl_wr_delay
    import ntt_ctrl_pkg::*;
#(
    parameter int LAT = wb_lat(MEM_LATENCY_DEF, BF_LATENCY_DEF),
    parameter int W   = 1 + 2 * LOG_N_DEF
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_dat,
    output logic [W-1:0] o_dat
);
    logic [W-1:0] r_pipe [LAT];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int k = 0; k < LAT; k++) begin
                r_pipe[k] <= '0;
            end
        end else begin
            r_pipe[0] <= i_dat;
            for (int k = 1; k < LAT; k++) begin
                r_pipe[k] <= r_pipe[k-1];
            end
        end
    end

    assign o_dat = r_pipe[LAT-1];
endmodule

// File: rtl/ntt_ctrl.sv
// Sequencer issuing one butterfly per cycle over all stages of an in-place NTT (CT) / INTT (GS);
// start->done takes 1 + LOG_N*(N/2+LAT) cycles, no backpressure, start ignored while busy.
module ntt_ctrl
    import ntt_ctrl_pkg::*;
#(
    parameter int LOG_N       = LOG_N_DEF,
    parameter int MEM_LATENCY = MEM_LATENCY_DEF,
    parameter int BF_LATENCY  = BF_LATENCY_DEF
) (
    input logic        i_clk,
    input logic        i_rst_n,
    ntt_ctrl_if.master io_bus
);
    localparam int LAT  = wb_lat(MEM_LATENCY, BF_LATENCY);
    localparam int HALF = xform_size(LOG_N) / 2;
    localparam int DW   = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int WD_W = 1 + 2 * LOG_N;

    localparam logic [LOG_N-1:0] ONE_V      = LOG_N'(1);
    localparam logic [LOG_N-1:0] HALF_V     = LOG_N'(HALF);
    localparam logic [LOG_N-1:0] LAST_STAGE = LOG_N'(LOG_N - 1);
    localparam logic [DW-1:0]    DRAIN_END  = DW'(LAT - 1);

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_select;
    logic             r_rd_en;
    logic [LOG_N-1:0] r_s;
    logic [LOG_N-1:0] r_g;
    logic [LOG_N-1:0] r_i;
    logic [LOG_N-1:0] r_rd_addr_1;
    logic [LOG_N-1:0] r_rd_addr_2;
    logic [LOG_N-1:0] r_tw_addr;
    logic [DW-1:0]    r_drain;

    logic             w_i_wrap;
    logic             w_last;
    logic             w_nx_mode;
    logic [LOG_N-1:0] w_len;
    logic [LOG_N-1:0] w_grp;
    logic [LOG_N-1:0] w_nx_s;
    logic [LOG_N-1:0] w_nx_g;
    logic [LOG_N-1:0] w_nx_i;
    logic [LOG_N-1:0] w_nx_len;
    logic [LOG_N-1:0] w_nx_grp;
    logic [LOG_N-1:0] w_nx_rd1;
    logic [LOG_N-1:0] w_nx_rd2;
    logic [LOG_N-1:0] w_nx_tw;
    logic [WD_W-1:0]  w_wr_dat;

    function automatic logic [LOG_N-1:0] stage_len(input logic mode, input logic [LOG_N-1:0] s);
        return mode ? (ONE_V << s) : (HALF_V >> s);
    endfunction

    // Group count doubles as the twiddle base index of the stage in both directions.
    function automatic logic [LOG_N-1:0] stage_groups(input logic mode, input logic [LOG_N-1:0] s);
        return mode ? (HALF_V >> s) : (ONE_V << s);
    endfunction

    always_comb begin
        w_len     = stage_len(r_select, r_s);
        w_grp     = stage_groups(r_select, r_s);
        w_i_wrap  = (r_i == w_len - ONE_V);
        w_last    = w_i_wrap && (r_g == w_grp - ONE_V);
        w_nx_mode = r_select;
        w_nx_s    = r_s;
        w_nx_g    = r_g;
        w_nx_i    = r_i + ONE_V;
        case (r_state)
            ST_IDLE: begin
                w_nx_mode = io_bus.mode;
                w_nx_s    = '0;
                w_nx_g    = '0;
                w_nx_i    = '0;
            end
            ST_ISSUE: begin
                if (w_i_wrap) begin
                    w_nx_g = r_g + ONE_V;
                    w_nx_i = '0;
                end
            end
            ST_DRAIN: begin
                w_nx_s = r_s + ONE_V;
                w_nx_g = '0;
                w_nx_i = '0;
            end
            default: ;
        endcase
        w_nx_len = stage_len(w_nx_mode, w_nx_s);
        w_nx_grp = stage_groups(w_nx_mode, w_nx_s);
        w_nx_rd1 = ((w_nx_g * w_nx_len) << 1) + w_nx_i;
        w_nx_rd2 = w_nx_rd1 + w_nx_len;
        w_nx_tw  = w_nx_grp + w_nx_g;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_select    <= 1'b0;
            r_rd_en     <= 1'b0;
            r_s         <= '0;
            r_g         <= '0;
            r_i         <= '0;
            r_rd_addr_1 <= '0;
            r_rd_addr_2 <= '0;
            r_tw_addr   <= '0;
            r_drain     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (io_bus.start) begin
                        r_state     <= ST_ISSUE;
                        r_busy      <= 1'b1;
                        r_select    <= io_bus.mode;
                        r_s         <= w_nx_s;
                        r_g         <= w_nx_g;
                        r_i         <= w_nx_i;
                        r_rd_en     <= 1'b1;
                        r_rd_addr_1 <= w_nx_rd1;
                        r_rd_addr_2 <= w_nx_rd2;
                        r_tw_addr   <= w_nx_tw;
                    end
                end
                ST_ISSUE: begin
                    if (w_last) begin
                        r_state <= ST_DRAIN;
                        r_rd_en <= 1'b0;
                        r_drain <= '0;
                    end else begin
                        r_g         <= w_nx_g;
                        r_i         <= w_nx_i;
                        r_rd_addr_1 <= w_nx_rd1;
                        r_rd_addr_2 <= w_nx_rd2;
                        r_tw_addr   <= w_nx_tw;
                    end
                end
                // Hold reads off until the stage's last write-back has landed.
                ST_DRAIN: begin
                    if (r_drain == DRAIN_END) begin
                        if (r_s != LAST_STAGE) begin
                            r_state     <= ST_ISSUE;
                            r_s         <= w_nx_s;
                            r_g         <= w_nx_g;
                            r_i         <= w_nx_i;
                            r_rd_en     <= 1'b1;
                            r_rd_addr_1 <= w_nx_rd1;
                            r_rd_addr_2 <= w_nx_rd2;
                            r_tw_addr   <= w_nx_tw;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    ntt_ctrl_wr_delay #(
        .LAT (LAT),
        .W   (WD_W)
    ) u_wr_delay (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_dat   ({r_rd_en, r_rd_addr_1, r_rd_addr_2}),
        .o_dat   (w_wr_dat)
    );

    assign io_bus.busy      = r_busy;
    assign io_bus.done      = r_done;
    assign io_bus.select    = r_select;
    assign io_bus.stage     = r_s;
    assign io_bus.rd_en     = r_rd_en;
    assign io_bus.rd_addr_1 = r_rd_addr_1;
    assign io_bus.rd_addr_2 = r_rd_addr_2;
    assign io_bus.tw_addr   = r_tw_addr;
    assign io_bus.wr_en     = w_wr_dat[WD_W-1];
    assign io_bus.wr_addr_1 = w_wr_dat[2*LOG_N-1:LOG_N];
    assign io_bus.wr_addr_2 = w_wr_dat[LOG_N-1:0];
endmodule

// File: tb/tb_ntt_ctrl.sv
// Bench for ntt_ctrl at N=8, LAT=2: per-cycle trace against a loop-built schedule, plus an NTT/INTT round trip.
module tb_ntt_ctrl;
    localparam int LN       = 3;
    localparam int N        = 1 << LN;
    localparam int HALF     = N / 2;
    localparam int MEM_LAT  = 1;
    localparam int BF_LAT   = 1;
    localparam int LAT      = MEM_LAT + BF_LAT;
    localparam int PER      = HALF + LAT;
    localparam int TDONE    = 1 + LN * PER;
    localparam int MAXC     = 40;
    localparam int Q        = 17;

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          select;
        logic [LN-1:0] stage;
        logic          rd_en;
        logic [LN-1:0] rd1;
        logic [LN-1:0] rd2;
        logic [LN-1:0] tw;
        logic          wr_en;
        logic [LN-1:0] wr1;
        logic [LN-1:0] wr2;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ntt_ctrl_if #(.LOG_N(LN)) bus();

    ntt_ctrl #(
        .LOG_N       (LN),
        .MEM_LATENCY (MEM_LAT),
        .BF_LATENCY  (BF_LAT)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus)
    );

    obs_t exp_a [0:MAXC];
    int   vectors = 0;
    int   miscompares = 0;
    int   ram  [N];
    int   zeta [N];
    int   izeta[N];
    int   pq_x [$];
    int   pq_y [$];

    // Expected per-cycle schedule, cycle 0 being the one in which start is sampled.
    function automatic void build_expect(input logic m);
        for (int c = 0; c <= MAXC; c++) exp_a[c] = '0;
        for (int c = 1; c <= TDONE + 1; c++) begin
            exp_a[c].select = m;
            exp_a[c].stage  = (c < TDONE) ? LN'((c - 1) / PER) : LN'(LN - 1);
            exp_a[c].busy   = (c < TDONE);
        end
        exp_a[TDONE].done = 1'b1;
        for (int s = 0; s < LN; s++) begin
            int len  = m ? (1 << s) : (N >> (s + 1));
            int grp  = N / 2 / len;
            int base = m ? (N >> (s + 1)) : (1 << s);
            for (int g = 0; g < grp; g++) begin
                for (int i = 0; i < len; i++) begin
                    int c  = 1 + s * PER + g * len + i;
                    int a1 = g * 2 * len + i;
                    exp_a[c].rd_en       = 1'b1;
                    exp_a[c].rd1         = LN'(a1);
                    exp_a[c].rd2         = LN'(a1 + len);
                    exp_a[c].tw          = LN'(base + g);
                    exp_a[c + LAT].wr_en = 1'b1;
                    exp_a[c + LAT].wr1   = LN'(a1);
                    exp_a[c + LAT].wr2   = LN'(a1 + len);
                end
            end
        end
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o        = '0;
        o.busy   = bus.busy;
        o.done   = bus.done;
        o.select = bus.select;
        o.stage  = bus.stage;
        o.rd_en  = bus.rd_en;
        o.wr_en  = bus.wr_en;
        if (bus.rd_en) begin
            o.rd1 = bus.rd_addr_1;
            o.rd2 = bus.rd_addr_2;
            o.tw  = bus.tw_addr;
        end
        if (bus.wr_en) begin
            o.wr1 = bus.wr_addr_1;
            o.wr2 = bus.wr_addr_2;
        end
        return o;
    endfunction

    // Behavioural RAM + twiddle ROM + radix-2 butterfly, one step per cycle.
    function automatic void mem_step();
        int a, b, z, t, x, y;
        if (bus.rd_en) begin
            a = ram[bus.rd_addr_1];
            b = ram[bus.rd_addr_2];
            if (bus.select) begin
                z = izeta[bus.tw_addr];
                x = (a + b) % Q;
                y = (((a - b + Q) % Q) * z) % Q;
            end else begin
                z = zeta[bus.tw_addr];
                t = (z * b) % Q;
                x = (a + t) % Q;
                y = (a - t + Q) % Q;
            end
            pq_x.push_back(x);
            pq_y.push_back(y);
        end
        if (bus.wr_en && pq_x.size() > 0) begin
            ram[bus.wr_addr_1] = pq_x.pop_front();
            ram[bus.wr_addr_2] = pq_y.pop_front();
        end
    endfunction

    task automatic test_sequence(input logic m, input int glitch_c, input int rst_c, input string tag);
        obs_t o;
        logic [5+6*LN-1:0] raw;
        build_expect(m);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.mode  = m;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.mode  = 1'($urandom_range(0, 1));
        for (int c = 1; c <= TDONE + 1; c++) begin
            @(negedge clk);
            o = sample();
            vectors++;
            if (o !== exp_a[c]) begin
                miscompares++;
                $display("FAIL %s cycle %0d: got %h want %h", tag, c, o, exp_a[c]);
            end
            if (c == glitch_c) begin
                bus.start = 1'b1;
                bus.mode  = ~m;
            end else if (c == glitch_c + 1) begin
                bus.start = 1'b0;
            end
            if (c == rst_c) begin
                rst_n = 1'b0;
                bus.start = 1'b0;
                @(negedge clk);
                raw = {bus.busy, bus.done, bus.select, bus.stage, bus.rd_en, bus.rd_addr_1,
                       bus.rd_addr_2, bus.tw_addr, bus.wr_en, bus.wr_addr_1, bus.wr_addr_2};
                vectors++;
                if (raw !== '0) begin
                    miscompares++;
                    $display("FAIL %s reset outputs: got %h want 0", tag, raw);
                end
                rst_n = 1'b1;
                for (int k = 0; k < LAT + 2; k++) begin
                    @(negedge clk);
                    vectors++;
                    if ({bus.busy, bus.rd_en, bus.wr_en} !== 3'b000) begin
                        miscompares++;
                        $display("FAIL %s post-reset k=%0d busy/rd/wr got %b want 000", tag, k,
                                 {bus.busy, bus.rd_en, bus.wr_en});
                    end
                end
                return;
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        logic [5+6*LN-1:0] raw;
        rst_n     = 1'b0;
        bus.start = 1'b1;
        bus.mode  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        raw = {bus.busy, bus.done, bus.select, bus.stage, bus.rd_en, bus.rd_addr_1,
               bus.rd_addr_2, bus.tw_addr, bus.wr_en, bus.wr_addr_1, bus.wr_addr_2};
        vectors++;
        if (raw !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got %h want 0", raw);
        end
        bus.start = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus.busy, bus.rd_en, bus.done} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_wins: busy/rd/done got %b want 000", {bus.busy, bus.rd_en, bus.done});
        end
    endtask

    task automatic test_ntt();
        repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            vectors++;
            if (bus.busy !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_busy: got %b want 0", bus.busy);
            end
        end
        test_sequence(1'b0, 0, 0, "ntt");
    endtask

    task automatic test_intt();
        test_sequence(1'b1, 0, 0, "intt");
    endtask

    task automatic test_start_ignored();
        test_sequence(1'b0, 5, 0, "ignore_c5");
        test_sequence(1'($urandom_range(0, 1)), $urandom_range(1, TDONE), 0, "ignore_rand");
    endtask

    task automatic test_mid_reset();
        test_sequence(1'b0, 0, 8, "reset_c8");
        test_sequence(1'b0, 0, 0, "after_reset");
        test_sequence(1'($urandom_range(0, 1)), 0, $urandom_range(1, TDONE), "reset_rand");
        test_sequence(1'($urandom_range(0, 1)), 0, 0, "after_reset_rand");
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) begin
            test_sequence(1'($urandom_range(0, 1)), 0, 0, "b2b");
        end
    endtask

    task automatic test_end_to_end();
        int refv [N];
        int kk, z, t, e, p;
        bit seen;
        for (int k = 0; k < N; k++) begin
            e = 0;
            for (int b = 0; b < LN; b++) e = e | (((k >> b) & 1) << (LN - 1 - b));
            p = 1;
            for (int r = 0; r < e; r++) p = (p * 3) % Q;
            zeta[k] = p;
            izeta[k] = 0;
            for (int v = 1; v < Q; v++) if ((v * p) % Q == 1) izeta[k] = v;
            ram[k]  = k + 1;
            refv[k] = k + 1;
        end
        kk = 1;
        for (int len = N / 2; len >= 1; len = len / 2) begin
            for (int st = 0; st < N; st += 2 * len) begin
                z = zeta[kk];
                kk++;
                for (int j = st; j < st + len; j++) begin
                    t = (z * refv[j + len]) % Q;
                    refv[j + len] = (refv[j] - t + Q) % Q;
                    refv[j] = (refv[j] + t) % Q;
                end
            end
        end
        pq_x.delete();
        pq_y.delete();
        for (int pass = 0; pass < 2; pass++) begin
            @(posedge clk); #1;
            bus.start = 1'b1;
            bus.mode  = (pass == 1);
            @(posedge clk); #1;
            bus.start = 1'b0;
            seen = 1'b0;
            for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
                @(negedge clk);
                mem_step();
                if (bus.done) seen = 1'b1;
            end
            vectors++;
            if (!seen) begin
                miscompares++;
                $display("FAIL e2e pass %0d done: got 0 want 1 within 200 cycles", pass);
            end
            for (int k = 0; k < N; k++) begin
                int want = (pass == 0) ? refv[k] : ((k + 1) * N) % Q;
                vectors++;
                if (ram[k] != want) begin
                    miscompares++;
                    $display("FAIL e2e pass %0d coef[%0d]: got %0d want %0d", pass, k, ram[k], want);
                end
            end
        end
        vectors++;
        if (pq_x.size() != 0) begin
            miscompares++;
            $display("FAIL e2e pending_writes: got %0d want 0", pq_x.size());
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        test_reset();
        test_ntt();
        test_intt();
        test_start_ignored();
        test_mid_reset();
        test_back_to_back();
        test_end_to_end();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ntt_ctrl.md
Name: ntt_ctrl

Overview:
- Sequencer that drives the radix_2 butterfly over a full N-point in-place NTT or INTT.
- Generates coefficient-pair read addresses, twiddle ROM address, mode select and write-back addresses/enables, stage by stage.
- Sits between the coefficient RAM/twiddle ROM and the butterfly; it is the initiator that feeds the butterfly datapath and commits its results.

Parameters:
- log_n, 8, log2 of transform size N (N = 1<<log_n).
- mem_latency, 1, read latency in cycles of coefficient RAM and twiddle ROM, both equal.
- bf_latency, 1, butterfly pipeline latency in cycles (0 = combinational).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  one-cycle request to begin a transform; sampled only in IDLE.
- mode  input  1  0 = NTT (CT), 1 = INTT (GS); latched with start.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse after the last write-back.
- select  output  1  latched mode, drives butterfly select.
- stage  output  log_n bits (clog2(log_n) minimum)  current stage index s.
- rd_en  output  1  read strobe for both RAM ports and twiddle ROM.
- rd_addr_1  output  log_n  upper-butterfly read address j.
- rd_addr_2  output  log_n  lower-butterfly read address j+len.
- tw_addr  output  log_n  twiddle ROM index.
- wr_en  output  1  write-back strobe for both RAM ports.
- wr_addr_1  output  log_n  write address for output_1.
- wr_addr_2  output  log_n  write address for output_2.

Behaviour:
- Reset (rst_n=0 at edge): state IDLE. busy, done, rd_en and wr_en are 0. All addresses, stage and select are 0. The write-delay pipeline is cleared, so no write occurs after a mid-transform reset.
- FSM: IDLE -> ISSUE -> DRAIN -> (ISSUE for the next stage | DONE) -> IDLE.
- IDLE: start=1 latches mode into select. Stage s=0, group g=0, offset i=0. Next state ISSUE.
- ISSUE: one butterfly per cycle, rd_en=1, N/2 cycles per stage.
  - NTT: len = N>>(s+1); groups = 1<<s; tw_addr = (1<<s)+g.
  - INTT: len = 1<<s; groups = N>>(s+1); tw_addr = (N>>(s+1))+g.
  - rd_addr_1 = g*2*len + i; rd_addr_2 = rd_addr_1 + len.
  - i increments and wraps at len, then g increments. After the last pair, go to DRAIN.
- Write-back: LAT = mem_latency + bf_latency. wr_en, wr_addr_1 and wr_addr_2 equal the rd_en/rd_addr values of LAT cycles earlier, via a shift register.
- DRAIN: rd_en=0 for exactly LAT cycles, so the last write of stage s lands before the first read of stage s+1 (RAW hazard avoided). Then s+1 < log_n goes to ISSUE with g=i=0; otherwise DONE.
- DONE: done=1, busy=0 for one cycle, then IDLE.
- Timing: start sampled at cycle 0 puts the first rd_en at cycle 1. done is high at cycle 1 + log_n*(N/2+LAT).
- start while busy is ignored; mode is not re-sampled.
- start and rst_n=0 in the same cycle: reset wins.
- Address arithmetic is unsigned log_n bits and never overflows by construction. Internal counters are one bit wider where needed for terminal detection.
- select and stage are stable for the whole transform and hold after done until the next start.

Decomposition:
- Shared package/header ntt_pkg: log_n, N, LAT derivation, and FSM state encoding (IDLE, ISSUE, DRAIN, DONE).
- One sub-module: ntt_wr_delay, a LAT-deep shift register carrying {wr_en, wr_addr_1, wr_addr_2}, cleared by rst_n.
- Address and twiddle generation stay inline.

Test Plan (log_n=3, N=8, mem_latency=1, bf_latency=1, LAT=2):
- NTT start at cycle 0 -> reads and tw_addr in this order:
  - stage 0: (0,4)(1,5)(2,6)(3,7), tw=1.
  - stage 1: (0,2)(1,3) tw=2; (4,6)(5,7) tw=3.
  - stage 2: (0,1)tw4 (2,3)tw5 (4,5)tw6 (6,7)tw7.
  - done at cycle 19.
- INTT start -> select=1; reads and tw_addr in this order:
  - stage 0: (0,1)tw4 (2,3)tw5 (4,5)tw6 (6,7)tw7.
  - stage 1: (0,2)(1,3) tw2, (4,6)(5,7) tw3.
  - stage 2: (0,4)..(3,7) tw1.
  - done at cycle 19.
- Write-back alignment -> each wr_en/wr_addr pair equals the rd pair exactly 2 cycles earlier. Stage 1 first rd_en (cycle 7) comes after stage 0 last wr_en (cycle 6).
- start pulsed again at cycle 5 with mode=1 -> ignored; select stays 0 and the sequence is unchanged.
- rst_n=0 at cycle 8 -> from the next cycle busy=0, rd_en=0, wr_en=0 with no pending writes. A subsequent start completes a full NTT normally.
- End-to-end with behavioural RAM, ROM and radix_2 -> NTT then INTT of [1..8] returns the original vector scaled by N mod q.
